// File: rtl/seq_mult8_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller.
// Drives an external 8-bit ripple-carry adder once per iteration and
// assembles the 16-bit product from its sum and carry-out over 8 cycles.
// All vector ports use ascending [0:N-1] ranges where index 0 is the LSB;
// internally everything is held in conventional [N-1:0] form and the two
// layouts are bridged bit-by-bit at the boundary.
module seq_mult8_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:WIDTH-1] mcand,
  input  logic [0:WIDTH-1] mplier,
  output logic [0:WIDTH-1] add_a,
  output logic [0:WIDTH-1] add_b,
  output logic             add_cin,
  input  logic [0:WIDTH-1] add_f,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [0:2*WIDTH-1] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Datapath registers, LSB at index 0 in the usual descending layout.
  logic [WIDTH-1:0]   m_reg, m_next;
  logic [WIDTH-1:0]   acc_hi_reg, acc_hi_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [2*WIDTH-1:0] product_reg, product_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  // Port-layout bridges: port index i always carries weight 2**i.
  logic [WIDTH-1:0]   mcand_v;
  logic [WIDTH-1:0]   mplier_v;
  logic [WIDTH-1:0]   add_f_v;
  logic [WIDTH-1:0]   add_b_v;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bridge8
      assign mcand_v[gi]  = mcand[gi];
      assign mplier_v[gi] = mplier[gi];
      assign add_f_v[gi]  = add_f[gi];
      assign add_a[gi]    = acc_hi_reg[gi];
      assign add_b[gi]    = add_b_v[gi];
    end
    for (gi = 0; gi < 2 * WIDTH; gi = gi + 1) begin : g_bridge16
      assign product[gi] = product_reg[gi];
    end
  endgenerate

  // Adder operand selection: the partial product is only offered while
  // iterating, so the adder sees a quiet zero on b the rest of the time.
  always_comb begin
    add_b_v = '0;
    if (state_reg == RUN && q_reg[0]) begin
      add_b_v = m_reg;
    end
  end

  assign add_cin = 1'b0;
  assign busy    = busy_reg;
  assign done    = done_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next   = state_reg;
    m_next       = m_reg;
    acc_hi_next  = acc_hi_reg;
    q_next       = q_reg;
    count_next   = count_reg;
    product_next = product_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          m_next      = mcand_v;
          q_next      = mplier_v;
          acc_hi_next = '0;
          count_next  = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        // Shift {cout, sum, q} right by one: the carry becomes the new MSB
        // of the accumulator and the sum LSB drops into the product low half.
        acc_hi_next = {add_cout, add_f_v[WIDTH-1:1]};
        q_next      = {add_f_v[0], q_reg[WIDTH-1:1]};
        count_next  = count_reg + CNT_W'(1);
        if (count_reg == CNT_W'(WIDTH - 1)) begin
          product_next = {acc_hi_next, q_next};
          state_next   = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Status flags are registered images of the state being entered, so
    // they line up exactly with RUN/DONE without decoding glitches.
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg       <= '0;
      acc_hi_reg  <= '0;
      q_reg       <= '0;
      count_reg   <= '0;
      product_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      m_reg       <= m_next;
      acc_hi_reg  <= acc_hi_next;
      q_reg       <= q_next;
      count_reg   <= count_next;
      product_reg <= product_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// Directed bench for seq_mult8_ctrl with an 8-bit adder model on the
// add_* ports and a product scoreboard fed at each accepted start.
module tb_seq_mult8_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [0:7]  mcand;
  logic [0:7]  mplier;
  logic [0:7]  add_a;
  logic [0:7]  add_b;
  logic        add_cin;
  logic [0:7]  add_f;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [0:15] product;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [8:0]  sum9;
  bit          saw_cout;
  bit          saw_b_nonzero;

  seq_mult8_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_f(add_f),
    .add_cout(add_cout), .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port index i carries weight 2**i.
  function automatic logic [0:7] to_p8(input logic [7:0] v);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] from_p8(input logic [0:7] p);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = p[i];
    return r;
  endfunction

  function automatic logic [15:0] from_p16(input logic [0:15] p);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = p[i];
    return r;
  endfunction

  // 8-bit ripple-carry adder model.
  always_comb begin
    sum9     = {1'b0, from_p8(add_a)} + {1'b0, from_p8(add_b)} + {8'd0, add_cin};
    add_f    = to_p8(sum9[7:0]);
    add_cout = sum9[8];
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from an IDLE cycle. Options: scramble operands in
  // every RUN cycle, reassert start (9x9) in RUN cycle 'again', and
  // reassert start in the DONE cycle.
  task automatic run_mult(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                          input bit scramble, input int again, input bit again_done);
    logic [15:0] exp_p;
    saw_cout      = 0;
    saw_b_nonzero = 0;
    start  = 1'b1;
    mcand  = to_p8(mc);
    mplier = to_p8(mp);
    exp_q.push_back(16'(mc) * 16'(mp));
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      check({tag, "_done_run"}, 32'(done), 32'd0);
      if (add_cout === 1'b1) saw_cout = 1;
      if (from_p8(add_b) !== 8'd0) saw_b_nonzero = 1;
      if (scramble) begin
        mcand  = to_p8(8'($urandom));
        mplier = to_p8(8'($urandom));
      end
      if (k == again) begin
        start  = 1'b1;
        mcand  = to_p8(8'd9);
        mplier = to_p8(8'd9);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
      exp_p = 16'hxxxx;
    end else begin
      exp_p = exp_q.pop_front();
      check({tag, "_product"}, 32'(from_p16(product)), 32'(exp_p));
    end
    if (again_done) begin
      start  = 1'b1;
      mcand  = to_p8(8'd9);
      mplier = to_p8(8'd9);
    end
    tick();
    start = 1'b0;
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_product_hold"}, 32'(from_p16(product)), 32'(exp_p));
    $display("txn %s: %0d x %0d -> product %0d", tag, mc, mp, from_p16(product));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(from_p16(product)), 32'd0);
    check("rst_add_a", 32'(from_p8(add_a)), 32'd0);
    check("rst_add_b", 32'(from_p8(add_b)), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    tick();

    run_mult("basic", 8'd4, 8'd2, 0, 0, 0);

    run_mult("max", 8'd255, 8'd255, 0, 0, 0);
    check("max_cout_seen", 32'(saw_cout), 32'd1);

    run_mult("zero_mc", 8'd0, 8'd173, 0, 0, 0);
    run_mult("zero_mp", 8'd173, 8'd0, 0, 0, 0);
    check("zero_mp_add_b", 32'(saw_b_nonzero), 32'd0);

    run_mult("busy_ign", 8'd5, 8'd7, 0, 3, 1);
    repeat (2) begin
      tick();
      check("busy_ign_no_restart", 32'(busy), 32'd0);
      check("busy_ign_single_done", 32'(done), 32'd0);
    end
    run_mult("after_ign", 8'd9, 8'd9, 0, 0, 0);

    // Reset in RUN cycle 4 aborts without a done pulse.
    start  = 1'b1;
    mcand  = to_p8(8'd200);
    mplier = to_p8(8'd3);
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(from_p16(product)), 32'd0);
    check("abort_add_a", 32'(from_p8(add_a)), 32'd0);
    $display("txn abort: 200 x 3 reset in run cycle 4 -> product %0d", from_p16(product));
    run_mult("post_abort", 8'd200, 8'd3, 0, 0, 0);

    // start and rst together: reset wins.
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    tick();
    check("rst_start_idle", 32'(busy), 32'd0);

    run_mult("stable", 8'd12, 8'd11, 1, 0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mult8_ctrl.md
Name: seq_mult8_ctrl

Overview:
- Sequential shift-and-add unsigned multiplier controller. It sits directly upstream of the team's 8-bit ripple-carry adder (FADDER chain) and reuses that adder for every partial-product addition.
- It accepts two 8-bit operands on a start pulse and drives the adder's a/b/cin inputs each cycle. It consumes the adder's f/cout and returns a 16-bit product after 8 iterations.

Parameters:
- WIDTH, 8, operand width; must equal the attached adder width (only 8 is supported).
- CNT_W, 3, iteration counter width; equals log2(WIDTH).

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mcand  input  8  multiplicand; latched on accepted start.
- mplier  input  8  multiplier; latched on accepted start.
- add_a  output  8  to adder a: current upper accumulator.
- add_b  output  8  to adder b: multiplicand if current multiplier LSB = 1, else 0.
- add_cin  output  1  to adder cin; constant 0.
- add_f  input  8  from adder f (sum).
- add_cout  input  1  from adder cout.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when product is valid.
- product  output  16  result; holds until the next accepted start or reset.
- All vectors are declared [0:N-1]; bit 0 is the LSB, matching the adder's ports.

Behaviour:
- Reset values: state = IDLE, busy = 0, done = 0, product = 0, internal acc_hi/q/m/count = 0, add_a = 0, add_b = 0, add_cin = 0.
- Internal registers:
  - m: 8-bit multiplicand.
  - acc_hi: 8-bit upper accumulator.
  - q: 8-bit lower half, initially the multiplier.
  - count: CNT_W bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at edge E0: m <= mcand, q <= mplier, acc_hi <= 0, count <= 0, go to RUN.
  - start = 0: stay in IDLE.
- RUN, every edge:
  - Adder path is combinational: add_a = acc_hi, add_b = q[0] ? m : 0, add_cin = 0.
  - Update (shift right by 1 of {add_cout, add_f, q}): acc_hi <= {add_cout, add_f[7:1]}, q <= {add_f[0], q[7:1]}, count <= count + 1.
  - When count = 7 (eighth iteration, edge E8): product <= {new acc_hi, new q}, go to DONE.
- DONE: done = 1 and busy = 0 for exactly this one cycle. Next edge E9: go to IDLE, done <= 0.
- Latency: start sampled at E0, done high in the cycle following E8; product visible in that same cycle. A new start is accepted no earlier than E9 (IDLE sampled at E9 is not possible), i.e. first acceptable at edge E10, sampled in IDLE.
- busy = 1 exactly in RUN (8 cycles).
- start is ignored in RUN and DONE; operands are not re-latched.
- mcand/mplier changes after E0 have no effect.
- Product is zero-extended unsigned; max 255*255 = 65025 fits in 16 bits. The adder's cout is always captured, so no overflow loss.
- Counter wrap: count reaches 7 and is not used after leaving RUN; it is reset to 0 on the next start.
- add_a/add_b outside RUN: add_a = acc_hi, add_b = 0. Adder outputs are ignored outside RUN.
- Reset mid-operation (any state): immediate return to reset values at that edge. No done pulse; product cleared to 0.
- start and rst asserted together: rst wins.
- Implementation: all outputs registered except add_a/add_b/add_cin (combinational from registers). No combinational path from start to any output.

Test Plan:
- Bench connects an 8-bit adder model to the add_* ports.
- Basic product: mcand = 4, mplier = 2, start pulse -> busy for 8 cycles, done pulse 9 cycles after the start edge, product = 16'd8.
- Maximum operands: mcand = 255, mplier = 255 -> product = 16'hFE01 (65025). add_cout = 1 observed in at least one RUN cycle.
- Zero operands: mcand = 0, mplier = 173 -> product = 0. Then mcand = 173, mplier = 0 -> add_b = 0 in all 8 RUN cycles, product = 0.
- Busy ignore: start 5 x 7; reassert start with 9 x 9 during RUN cycle 3 and in the DONE cycle -> product = 35, single done pulse. The next start, accepted only from IDLE, yields 81.
- Reset mid-run: start 200 x 3, assert rst in RUN cycle 4 -> next cycle busy = 0, done = 0, product = 0, state IDLE. A following start 200 x 3 gives product = 600 with full 9-cycle latency.
- Operand stability: change mcand/mplier every cycle after an accepted 12 x 11 -> product = 132.
